ahb_arbiter: RTL
================

Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter that shares one AHB address/data path between up to NUM_MASTERS masters.
- Drives HGRANT to the masters, and HMASTER/HMASTLOCK to the address mux and the slaves.
- Observes HTRANS, HBURST, HREADY and HRESP on the shared bus so that grant changes occur only on legal AHB boundaries.
- Sits between the master ports and the decoder/slave fabric.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- MW, 2, width of HMASTER; must satisfy 2**MW >= NUM_MASTERS.
- DEF_MASTER, 0, master granted when nobody requests, and out of reset.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  shared-bus transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST  in  3  shared-bus burst type.
- HREADY  in  1  shared-bus ready (transfer accepted when 1).
- HRESP  in  2  shared-bus response (00 OKAY, 01 ERROR).
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  MW  index of the master owning the current address phase, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.

Behaviour:
- Reset (HRESETn=0 at HCLK edge):
  - HGRANT=one-hot(DEF_MASTER), HMASTER=DEF_MASTER, HMASTLOCK=0.
  - Round-robin pointer=DEF_MASTER, state=ARB_IDLE.
  - Burst counter=0.
- A reset asserted mid-burst or mid-lock abandons it immediately; there is no drain.
- State machine (registered):
  - ARB_IDLE: default master granted, no requests. Any HBUSREQ bit set and HREADY=1 → grant the winner → ARB_OWN.
  - ARB_OWN: winner owns the bus.
    - HLOCK[owner]=1 → ARB_LOCK.
    - Re-arbitration allowed when HREADY=1, HBUSREQ[owner]=0 and hold=0. Then: other requests present → new winner (stay ARB_OWN); none → DEF_MASTER, ARB_IDLE.
  - ARB_LOCK: no re-arbitration while HLOCK[owner]=1. After HLOCK[owner] falls, the grant is held for exactly one more HREADY=1 cycle, then the ARB_OWN rules apply.
- Winner selection: rotating priority. Search starts at (pointer+1) mod NUM_MASTERS; the first set HBUSREQ bit wins. The pointer is loaded with the winner on every grant change.
- The owner continuing to request keeps the grant; there is no preemption.
- HGRANT changes only at an HCLK edge where HREADY=1. It is held unchanged through wait states (HREADY=0).
- HMASTER/HMASTLOCK: at each edge with HREADY=1, HMASTER←index(HGRANT) and HMASTLOCK←HLOCK[index(HGRANT)]. Otherwise both hold. This gives one cycle of latency from grant to address-phase ownership.
- HGRANT is always exactly one-hot, never zero.
- Simultaneous requests from all masters with the pointer at NUM_MASTERS-1: master 0 wins (wrap-around).
- hold=0 always unless the optional feature is enabled.

Optional Feature:
- Macro: AHB_ARB_BURST_HOLD_EN.
- With it: a 4-bit beat counter is added.
  - NONSEQ accepted (HTRANS=10, HREADY=1): load beats-1 (INCR4/WRAP4→3, INCR8/WRAP8→7, INCR16/WRAP16→15, SINGLE/INCR→0).
  - SEQ accepted: decrement, saturating at 0.
  - hold = (counter != 0). Grant is held until the last beat's address is accepted, even if HBUSREQ drops.
  - HRESP=ERROR with HREADY=0 clears the counter, so the master may abandon the burst.
- Without it: no counter; the grant follows HBUSREQ/HLOCK only.

Decomposition:
- Package ahb_arb_pkg holds:
  - HTRANS, HBURST and HRESP encoding constants.
  - The arbiter state enum (ARB_IDLE, ARB_OWN, ARB_LOCK).
  - A function mapping HBURST to beats-1.
- One combinational sub-module, ahb_arb_rr_pick, takes the request vector and pointer and returns the one-hot winner and its index.

Test Plan:
- Reset with HBUSREQ=4'b0000 → HGRANT=0001, HMASTER=0, HMASTLOCK=0. Then HBUSREQ=4'b0100, HREADY=1 → HGRANT=0100 next edge, HMASTER=2 the edge after.
- HBUSREQ=4'b1111, owner releases each cycle, HREADY=1 → grant order 1,2,3,0,1.
- Owner=1, HREADY=0 for 3 cycles while HBUSREQ[1] falls → HGRANT stays 0010 until the first HREADY=1 edge, then moves to the next requester.
- HLOCK[3]=1 with master 3 granted, others requesting → HGRANT=1000 and HMASTLOCK=1 throughout. After HLOCK[3]=0, the grant changes after one further HREADY=1 cycle.
- With AHB_ARB_BURST_HOLD_EN: master 1 issues NONSEQ with HBURST=INCR4 (011) and drops HBUSREQ after beat 1 → grant held through 3 SEQ beats, moves on the 4th accepted address. Repeat with HRESP=01, HREADY=0 at beat 2 → grant released at the next HREADY=1.
- HRESETn=0 mid INCR8 burst with grant on master 2 → next edge HGRANT=0001, HMASTER=0, counter=0.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arb_pkg
// Brief    : Shared AHB encodings, arbiter state type and burst-length helper.
// Revision : 1.0  initial release
// ============================================================================
package ahb_arb_pkg;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] c_HBURST_SINGLE = 3'b000;
  localparam logic [2:0] c_HBURST_INCR   = 3'b001;
  localparam logic [2:0] c_HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] c_HBURST_INCR4  = 3'b011;
  localparam logic [2:0] c_HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] c_HBURST_INCR8  = 3'b101;
  localparam logic [2:0] c_HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] c_HBURST_INCR16 = 3'b111;

  localparam logic [1:0] c_HRESP_OKAY    = 2'b00;
  localparam logic [1:0] c_HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_LOCK = 2'd2
  } arb_state_t;

  // Beats remaining after the NONSEQ beat; undefined-length bursts count as one.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] r;
    case (hburst)
      c_HBURST_WRAP4,  c_HBURST_INCR4:  r = 4'd3;
      c_HBURST_WRAP8,  c_HBURST_INCR8:  r = 4'd7;
      c_HBURST_WRAP16, c_HBURST_INCR16: r = 4'd15;
      c_HBURST_SINGLE, c_HBURST_INCR:   r = 4'd0;
      default:                          r = 4'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arb_rr_pick
// Brief    : Rotating-priority request picker, search begins after i_ptr.
// Revision : 1.0  initial release
// ============================================================================
module ahb_arb_rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MW-1:0]          i_ptr,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic [MW-1:0]          o_idx,
  output logic                   o_any
);

  int w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      // ptr < NUM_MASTERS and i <= NUM_MASTERS, so one subtraction wraps it
      w_idx = int'(i_ptr) + i;
      if (w_idx >= NUM_MASTERS) begin
        w_idx = w_idx - NUM_MASTERS;
      end
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx[MW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arbiter
// Brief    : Round-robin AHB arbiter; AHB_ARB_BURST_HOLD_EN adds burst hold.
// Revision : 1.0  initial release
// ============================================================================
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2,
  parameter int DEF_MASTER  = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] c_DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;
  localparam logic [MW-1:0] c_DEF_IDX = MW'(DEF_MASTER);

  arb_state_t             r_state,  w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant,  w_grant_nxt;
  logic [MW-1:0]          r_owner,  w_owner_nxt;
  logic [MW-1:0]          r_ptr,    w_ptr_nxt;
  logic [MW-1:0]          r_master;
  logic                   r_mastlock;

  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [MW-1:0]          w_pick_idx;
  logic                   w_pick_any;
  logic                   w_owner_req;
  logic                   w_owner_lock;
  logic                   w_hold;

  ahb_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_pick (
    .i_req   (HBUSREQ),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_owner_req  = HBUSREQ[r_owner];
  assign w_owner_lock = HLOCK[r_owner];

`ifdef AHB_ARB_BURST_HOLD_EN
  logic [3:0] r_beats;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_beats <= 4'd0;
    end else if (HREADY && (HTRANS == c_HTRANS_NONSEQ)) begin
      r_beats <= burst_beats_m1(HBURST);
    end else if (HREADY && (HTRANS == c_HTRANS_SEQ)) begin
      if (r_beats != 4'd0) begin
        r_beats <= r_beats - 4'd1;
      end
    end else if (!HREADY && (HRESP == c_HRESP_ERROR)) begin
      // first cycle of an ERROR response: let the master abandon the burst
      r_beats <= 4'd0;
    end
  end

  assign w_hold = (r_beats != 4'd0);
`else
  logic w_unused_bus;
  assign w_unused_bus = ^{HTRANS, HBURST, HRESP};
  assign w_hold       = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (HREADY && w_pick_any) begin
          w_grant_nxt = w_pick_grant;
          w_owner_nxt = w_pick_idx;
          w_ptr_nxt   = w_pick_idx;
          w_state_nxt = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (w_owner_lock) begin
          w_state_nxt = ARB_LOCK;
        end else if (HREADY && !w_owner_req && !w_hold) begin
          if (w_pick_any) begin
            w_grant_nxt = w_pick_grant;
            w_owner_nxt = w_pick_idx;
            w_ptr_nxt   = w_pick_idx;
          end else begin
            w_grant_nxt = c_DEF_GRANT;
            w_owner_nxt = c_DEF_IDX;
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      ARB_LOCK: begin
        // the accepting edge after HLOCK falls only returns to OWN, keeping the grant
        if (!w_owner_lock && HREADY) begin
          w_state_nxt = ARB_OWN;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = c_DEF_GRANT;
        w_owner_nxt = c_DEF_IDX;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= ARB_IDLE;
      r_grant    <= c_DEF_GRANT;
      r_owner    <= c_DEF_IDX;
      r_ptr      <= c_DEF_IDX;
      r_master   <= c_DEF_IDX;
      r_mastlock <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      if (HREADY) begin
        r_master   <= r_owner;
        r_mastlock <= w_owner_lock;
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule
`default_nettype wire
